// File: rtl/uart_cmd_handler.sv
// Frame command responder: decodes rx read/write frames to a register bank, replies once per valid-header frame.
// Latency: reply valid 3 cycles after accept, write lands at the same point; one frame in flight, tx stalls hold the FSM in RESP.
module uart_cmd_handler #(
  parameter int         REG_NUM = 8,
  parameter logic [7:0] HEADER  = 8'hA5
) (
  input  logic                   sys_clk,
  input  logic                   reset_n,
  input  logic [31:0]            rx_data1_in,
  input  logic [31:0]            rx_data2_in,
  input  logic                   rx_valid_in,
  output logic                   rx_ready_out,
  output logic [31:0]            tx_data1_out,
  output logic [31:0]            tx_data2_out,
  output logic                   tx_valid_out,
  input  logic                   tx_ready_in,
  input  logic [31:0]            status_in,
  output logic [REG_NUM*32-1:0]  ctrl_regs_out,
  output logic                   cmd_err_out
);

  typedef struct packed {
    logic [7:0] hdr;
    logic [7:0] op;
    logic [7:0] addr;
    logic [7:0] cs;
  } hdr_t;

  typedef enum logic [1:0] {IDLE, CHECK, EXEC, RESP} state_t;

  localparam logic [7:0] CMD_WR      = 8'h01;
  localparam logic [7:0] CMD_RD      = 8'h02;
  localparam logic [7:0] ADDR_STATUS = 8'hFF;
  localparam logic [7:0] CODE_WR_OK  = 8'h81;
  localparam logic [7:0] CODE_RD_OK  = 8'h82;
  localparam logic [7:0] CODE_CS_ERR = 8'hE1;
  localparam logic [7:0] CODE_OP_ERR = 8'hE2;
  localparam logic [7:0] CODE_AD_ERR = 8'hE3;
  localparam logic [7:0] REG_LIMIT   = 8'(REG_NUM);

  state_t      state_q, state_d;
  hdr_t        rx_hdr_q;
  logic [31:0] rx_dat_q;
  logic [7:0]  cs_q;
  logic [31:0] regs_q [REG_NUM];
  hdr_t        tx_hdr_q;
  logic [31:0] tx_dat_q;
  logic        err_q;

  logic [7:0]  cs_calc;
  logic [31:0] rd_data;
  logic [7:0]  code_d;
  logic [31:0] dat_d;
  logic        wr_en;
  logic        reply_err;
  logic        err_set;
  logic        rx_accept;
  hdr_t        tx_hdr_d;

  assign cs_calc = rx_hdr_q.hdr ^ rx_hdr_q.op ^ rx_hdr_q.addr ^
                   rx_dat_q[31:24] ^ rx_dat_q[23:16] ^ rx_dat_q[15:8] ^ rx_dat_q[7:0];

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (rx_hdr_q.addr == 8'(i)) rd_data = regs_q[i];
    end
  end

  // Reply selection; the order of the checks is the error precedence.
  always_comb begin
    code_d    = CODE_RD_OK;
    dat_d     = '0;
    wr_en     = 1'b0;
    reply_err = 1'b1;
    if (cs_q != rx_hdr_q.cs) begin
      code_d = CODE_CS_ERR;
    end else if (rx_hdr_q.op != CMD_WR && rx_hdr_q.op != CMD_RD) begin
      code_d = CODE_OP_ERR;
    end else if (rx_hdr_q.op == CMD_WR && rx_hdr_q.addr >= REG_LIMIT) begin
      code_d = CODE_AD_ERR;
    end else if (rx_hdr_q.op == CMD_RD && rx_hdr_q.addr >= REG_LIMIT &&
                 rx_hdr_q.addr != ADDR_STATUS) begin
      code_d = CODE_AD_ERR;
    end else if (rx_hdr_q.op == CMD_WR) begin
      code_d    = CODE_WR_OK;
      dat_d     = rx_dat_q;
      wr_en     = 1'b1;
      reply_err = 1'b0;
    end else begin
      code_d    = CODE_RD_OK;
      dat_d     = (rx_hdr_q.addr == ADDR_STATUS) ? status_in : rd_data;
      reply_err = 1'b0;
    end
  end

  always_comb begin
    tx_hdr_d.hdr  = HEADER;
    tx_hdr_d.op   = code_d;
    tx_hdr_d.addr = rx_hdr_q.addr;
    tx_hdr_d.cs   = HEADER ^ code_d ^ rx_hdr_q.addr ^
                    dat_d[31:24] ^ dat_d[23:16] ^ dat_d[15:8] ^ dat_d[7:0];
  end

  always_comb begin
    state_d      = state_q;
    rx_ready_out = 1'b0;
    tx_valid_out = 1'b0;
    err_set      = 1'b0;
    case (state_q)
      IDLE: begin
        rx_ready_out = 1'b1;
        if (rx_valid_in) state_d = CHECK;
      end
      CHECK: begin
        if (rx_hdr_q.hdr != HEADER) begin
          err_set = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        err_set = reply_err;
        state_d = RESP;
      end
      RESP: begin
        tx_valid_out = 1'b1;
        if (tx_ready_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_accept = rx_valid_in && rx_ready_out;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rx_hdr_q <= '0;
      rx_dat_q <= '0;
      cs_q     <= '0;
      tx_hdr_q <= '0;
      tx_dat_q <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_set;
      if (rx_accept) begin
        rx_hdr_q <= hdr_t'(rx_data1_in);
        rx_dat_q <= rx_data2_in;
      end
      if (state_q == CHECK) cs_q <= cs_calc;
      if (state_q == EXEC) begin
        tx_hdr_q <= tx_hdr_d;
        tx_dat_q <= dat_d;
        for (int i = 0; i < REG_NUM; i++) begin
          if (wr_en && rx_hdr_q.addr == 8'(i)) regs_q[i] <= rx_dat_q;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < REG_NUM; i++) ctrl_regs_out[32*i +: 32] = regs_q[i];
  end

  assign tx_data1_out = tx_hdr_q;
  assign tx_data2_out = tx_dat_q;
  assign cmd_err_out  = err_q;

endmodule

// File: tb/tb_uart_cmd_handler.sv
// Directed plus randomized frames against a queue-free reference model of the register bank.
module tb_uart_cmd_handler;
  localparam int         REG_NUM = 8;
  localparam logic [7:0] HDR     = 8'hA5;

  logic                  sys_clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [31:0]           rx_data1_in = '0;
  logic [31:0]           rx_data2_in = '0;
  logic                  rx_valid_in = 1'b0;
  logic                  rx_ready_out;
  logic [31:0]           tx_data1_out;
  logic [31:0]           tx_data2_out;
  logic                  tx_valid_out;
  logic                  tx_ready_in = 1'b0;
  logic [31:0]           status_in = '0;
  logic [REG_NUM*32-1:0] ctrl_regs_out;
  logic                  cmd_err_out;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mregs [REG_NUM];
  logic [31:0] last_tx1, last_tx2;

  uart_cmd_handler #(.REG_NUM(REG_NUM), .HEADER(HDR)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n),
    .rx_data1_in(rx_data1_in), .rx_data2_in(rx_data2_in),
    .rx_valid_in(rx_valid_in), .rx_ready_out(rx_ready_out),
    .tx_data1_out(tx_data1_out), .tx_data2_out(tx_data2_out),
    .tx_valid_out(tx_valid_out), .tx_ready_in(tx_ready_in),
    .status_in(status_in), .ctrl_regs_out(ctrl_regs_out),
    .cmd_err_out(cmd_err_out)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < REG_NUM; i++)
      check($sformatf("%s_reg%0d", tag, i), ctrl_regs_out[32*i +: 32], mregs[i]);
  endtask

  function automatic logic [7:0] xor4(input logic [31:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

  function automatic logic [31:0] frame1(input logic [7:0] h, input logic [7:0] cmd,
                                         input logic [7:0] addr, input logic [31:0] d2,
                                         input bit bad_cs);
    logic [7:0] cs;
    cs = h ^ cmd ^ addr ^ xor4(d2);
    if (bad_cs) cs = ~cs;
    return {h, cmd, addr, cs};
  endfunction

  // Reference behaviour: header gate, then error precedence, then the register access.
  task automatic model(input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] st,
                       output bit hdr_ok, output logic [7:0] code, output logic [31:0] data);
    logic [7:0] cmd, addr, cs;
    cmd    = d1[23:16];
    addr   = d1[15:8];
    cs     = d1[31:24] ^ cmd ^ addr ^ xor4(d2);
    hdr_ok = (d1[31:24] == HDR);
    code   = 8'h00;
    data   = '0;
    if (!hdr_ok) return;
    if (cs != d1[7:0]) code = 8'hE1;
    else if (cmd != 8'h01 && cmd != 8'h02) code = 8'hE2;
    else if (cmd == 8'h01 && int'(addr) >= REG_NUM) code = 8'hE3;
    else if (cmd == 8'h02 && int'(addr) >= REG_NUM && addr != 8'hFF) code = 8'hE3;
    else if (cmd == 8'h01) begin
      code = 8'h81;
      data = d2;
      mregs[addr] = d2;
    end else begin
      code = 8'h82;
      data = (addr == 8'hFF) ? st : mregs[addr];
    end
  endtask

  task automatic do_frame(input logic [31:0] d1, input logic [31:0] d2, input int hold);
    bit          ok;
    logic [7:0]  code;
    logic [31:0] data, exp1;
    int          n;
    n = 0;
    while (rx_ready_out !== 1'b1 && n < 50) begin
      @(posedge sys_clk); #1;
      n++;
    end
    if (rx_ready_out !== 1'b1) begin
      checks++;
      errors++;
      $error("FAIL ready_timeout: observed %b expected 1", rx_ready_out);
      return;
    end
    model(d1, d2, status_in, ok, code, data);
    exp1 = {HDR, code, d1[15:8], HDR ^ code ^ d1[15:8] ^ xor4(data)};
    tx_ready_in = (hold == 0);
    rx_data1_in = d1;
    rx_data2_in = d2;
    rx_valid_in = 1'b1;
    @(posedge sys_clk); #1;
    rx_valid_in = 1'b0;
    rx_data1_in = $urandom;
    rx_data2_in = $urandom;
    check1("busy_after_accept", rx_ready_out, 1'b0);
    @(posedge sys_clk); #1;
    if (!ok) begin
      check1("hdr_err_pulse", cmd_err_out, 1'b1);
      check1("hdr_no_tx", tx_valid_out, 1'b0);
      @(posedge sys_clk); #1;
      check1("hdr_ready_back", rx_ready_out, 1'b1);
      check1("hdr_err_one_cycle", cmd_err_out, 1'b0);
      check1("hdr_no_tx_late", tx_valid_out, 1'b0);
      return;
    end
    check1("no_early_err", cmd_err_out, 1'b0);
    check1("no_early_tx", tx_valid_out, 1'b0);
    @(posedge sys_clk); #1;
    check1("tx_valid", tx_valid_out, 1'b1);
    check("tx_data1", tx_data1_out, exp1);
    check("tx_data2", tx_data2_out, data);
    check1("err_pulse", cmd_err_out, code[7:4] == 4'hE);
    check1("busy_resp", rx_ready_out, 1'b0);
    check_regs("after_exec");
    last_tx1 = tx_data1_out;
    last_tx2 = tx_data2_out;
    for (int k = 0; k < hold; k++) begin
      @(posedge sys_clk); #1;
      check1("hold_valid", tx_valid_out, 1'b1);
      check("hold_data1", tx_data1_out, exp1);
      check("hold_data2", tx_data2_out, data);
      check1("hold_busy", rx_ready_out, 1'b0);
      check1("hold_no_err", cmd_err_out, 1'b0);
    end
    tx_ready_in = 1'b1;
    @(posedge sys_clk); #1;
    check1("tx_done", tx_valid_out, 1'b0);
    check1("ready_after_tx", rx_ready_out, 1'b1);
    check1("err_cleared", cmd_err_out, 1'b0);
  endtask

  initial begin
    logic [7:0]  h, cmd, addr;
    logic [31:0] d2;
    bit          bad_cs;

    for (int i = 0; i < REG_NUM; i++) mregs[i] = '0;
    #1;
    check1("rst_rx_ready", rx_ready_out, 1'b1);
    check1("rst_tx_valid", tx_valid_out, 1'b0);
    check("rst_tx_data1", tx_data1_out, 32'h0);
    check("rst_tx_data2", tx_data2_out, 32'h0);
    check1("rst_err", cmd_err_out, 1'b0);
    check1("rst_regs", ctrl_regs_out == '0, 1'b1);
    repeat (3) @(posedge sys_clk);
    #1 reset_n = 1'b1;
    @(posedge sys_clk); #1;

    do_frame(32'hA5010280, 32'h00001234, 0);
    check("wr_reply1", last_tx1, 32'hA5810200);
    check("wr_reply2", last_tx2, 32'h00001234);
    check("wr_reg2", ctrl_regs_out[95:64], 32'h00001234);

    do_frame(32'hA50202A5, 32'h0, 2);
    check("rd_reply1", last_tx1, 32'hA5820203);
    check("rd_reply2", last_tx2, 32'h00001234);

    do_frame(32'hA5010281, 32'h00001234, 1);
    check("cs_reply1", last_tx1, 32'hA5E10246);
    check("cs_reply2", last_tx2, 32'h0);
    check("cs_reg2_kept", ctrl_regs_out[95:64], 32'h00001234);

    do_frame(32'h5A010280, 32'h00001234, 0);

    status_in = 32'hDEADBEEF;
    do_frame(frame1(HDR, 8'h02, 8'hFF, 32'h0, 1'b0), 32'h0, 0);
    check("status_data", last_tx2, 32'hDEADBEEF);
    check("status_code", {24'h0, last_tx1[23:16]}, 32'h82);

    do_frame(frame1(HDR, 8'h01, 8'h07, 32'hCAFEF00D, 1'b0), 32'hCAFEF00D, 20);
    do_frame(frame1(HDR, 8'h01, 8'h08, 32'h11111111, 1'b0), 32'h11111111, 0);
    do_frame(frame1(HDR, 8'h02, 8'h08, 32'h0, 1'b0), 32'h0, 0);
    do_frame(frame1(HDR, 8'h07, 8'h01, 32'h0, 1'b0), 32'h0, 0);

    for (int t = 0; t < 60; t++) begin
      int r;
      r    = $urandom_range(0, 9);
      cmd  = (r < 4) ? 8'h01 : (r < 8) ? 8'h02 : 8'($urandom);
      r    = $urandom_range(0, 9);
      addr = (r < 7) ? 8'($urandom_range(0, REG_NUM - 1)) : (r == 7) ? 8'hFF : 8'($urandom);
      h    = ($urandom_range(0, 9) == 0) ? (HDR ^ 8'($urandom_range(1, 255))) : HDR;
      bad_cs = ($urandom_range(0, 9) == 0);
      d2   = $urandom;
      status_in = $urandom;
      do_frame(frame1(h, cmd, addr, d2, bad_cs), d2, $urandom_range(0, 3));
    end

    tx_ready_in = 1'b0;
    rx_data1_in = frame1(HDR, 8'h01, 8'h03, 32'h55AA55AA, 1'b0);
    rx_data2_in = 32'h55AA55AA;
    rx_valid_in = 1'b1;
    @(posedge sys_clk); #1;
    rx_valid_in = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    check1("pre_rst_valid", tx_valid_out, 1'b1);
    repeat (3) @(posedge sys_clk);
    #1 reset_n = 1'b0;
    #1;
    check1("mid_rst_valid", tx_valid_out, 1'b0);
    check("mid_rst_data1", tx_data1_out, 32'h0);
    check("mid_rst_data2", tx_data2_out, 32'h0);
    check1("mid_rst_err", cmd_err_out, 1'b0);
    check1("mid_rst_ready", rx_ready_out, 1'b1);
    check1("mid_rst_regs", ctrl_regs_out == '0, 1'b1);
    for (int i = 0; i < REG_NUM; i++) mregs[i] = '0;
    @(posedge sys_clk);
    #1 reset_n = 1'b1;
    @(posedge sys_clk); #1;
    do_frame(frame1(HDR, 8'h02, 8'h03, 32'h0, 1'b0), 32'h0, 1);
    check("post_rst_read", last_tx2, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
